// File: rtl/clock_lock_monitor.sv
// clock_lock_monitor
//
// Supervises the clock_manager outputs from the input_clk domain. The system
// reset is held until all three DCM lock flags have been high and stable, and
// the derived clock has been measured within tolerance over a full window.
// An out-of-range measurement triggers a DCM reset pulse. Repeated failures
// latch a sticky fault.
//
// Ports
//   input_clk          : single clock
//   reset              : synchronous, active-high
//   dcm_locked_in[2:0] : async lock flags (bit0 main, bit1 two, bit2 sram)
//   monitored_clock    : async derived clock, sampled as data
//   system_reset       : active-high reset to the rest of the design
//   clock_ok           : high only while running
//   dcm_reset_request  : active-high DCM reset pulse
//   fault              : sticky fatal fault
//   edge_count[15:0]   : edge count from the last completed window
//   retry_count[3:0]   : recoveries since the last RUN entry
//
// state     | meaning
// ----------+---------------------------------------------------------------
// WAIT_LOCK | waiting for all three lock flags, stability counter held at 0
// STABILIZE | counting consecutive all-locked cycles
// MEASURE   | first measurement window, system still held in reset
// RUN       | clocks good, reset released, windows repeat back to back
// RECOVER   | DCM reset pulse in progress
// FAULT     | terminal until reset

module clock_lock_monitor #(
   parameter int STABLE_CYCLES      = 1024,
   parameter int WINDOW_CYCLES      = 1000,
   parameter int EXPECT_EDGES       = 50,
   parameter int TOLERANCE          = 2,
   parameter int RESET_PULSE_CYCLES = 10,
   parameter int MAX_RETRIES        = 3
) (
   input  logic        input_clk,
   input  logic        reset,
   input  logic [2:0]  dcm_locked_in,
   input  logic        monitored_clock,
   output logic        system_reset,
   output logic        clock_ok,
   output logic        dcm_reset_request,
   output logic        fault,
   output logic [15:0] edge_count,
   output logic [3:0]  retry_count
);

   localparam int STAB_W  = (STABLE_CYCLES > 1)      ? $clog2(STABLE_CYCLES)      : 1;
   localparam int WIN_W   = (WINDOW_CYCLES > 1)      ? $clog2(WINDOW_CYCLES)      : 1;
   localparam int PULSE_W = (RESET_PULSE_CYCLES > 1) ? $clog2(RESET_PULSE_CYCLES) : 1;

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      STABILIZE = 3'd1,
      MEASURE   = 3'd2,
      RUN       = 3'd3,
      RECOVER   = 3'd4,
      FAULT     = 3'd5
   } state_t;

   state_t             state;
   logic [2:0]         lock_s1;
   logic [2:0]         lock_s2;
   logic               mclk_s1;
   logic               mclk_s2;
   logic               mclk_s3;
   logic [STAB_W-1:0]  stab_cnt;
   logic [WIN_W-1:0]   win_timer;
   logic [PULSE_W-1:0] pulse_timer;
   logic [15:0]        edge_cnt;

   logic               all_locked;
   logic               edge_pulse;
   logic [15:0]        count_next;
   logic [31:0]        count_ext;
   logic               in_range;

   assign all_locked = &lock_s2;
   assign edge_pulse = mclk_s2 & ~mclk_s3;

   // Count including this cycle's edge so a window-final edge is not lost.
   // The lower bound is tested as count + TOLERANCE >= EXPECT, which clamps
   // the bound at zero without underflow.
   always_comb begin
      count_next = edge_cnt;
      if (edge_pulse && (edge_cnt != 16'hFFFF)) begin
         count_next = edge_cnt + 16'd1;
      end
      count_ext = {16'd0, count_next};
      in_range  = ((count_ext + 32'(TOLERANCE)) >= 32'(EXPECT_EDGES)) &&
                  (count_ext <= 32'(EXPECT_EDGES + TOLERANCE));
   end

   always_ff @(posedge input_clk) begin
      if (reset) begin
         state             <= WAIT_LOCK;
         lock_s1           <= 3'b000;
         lock_s2           <= 3'b000;
         mclk_s1           <= 1'b0;
         mclk_s2           <= 1'b0;
         mclk_s3           <= 1'b0;
         stab_cnt          <= '0;
         win_timer         <= '0;
         pulse_timer       <= '0;
         edge_cnt          <= 16'd0;
         system_reset      <= 1'b1;
         clock_ok          <= 1'b0;
         dcm_reset_request <= 1'b0;
         fault             <= 1'b0;
         edge_count        <= 16'd0;
         retry_count       <= 4'd0;
      end else begin
         lock_s1 <= dcm_locked_in;
         lock_s2 <= lock_s1;
         mclk_s1 <= monitored_clock;
         mclk_s2 <= mclk_s1;
         mclk_s3 <= mclk_s2;

         case (state)
            WAIT_LOCK: begin
               stab_cnt          <= '0;
               system_reset      <= 1'b1;
               clock_ok          <= 1'b0;
               dcm_reset_request <= 1'b0;
               if (all_locked) begin
                  state <= STABILIZE;
               end
            end

            STABILIZE: begin
               if (!all_locked) begin
                  state    <= WAIT_LOCK;
                  stab_cnt <= '0;
               end else if (stab_cnt == STAB_W'(STABLE_CYCLES - 1)) begin
                  state     <= MEASURE;
                  stab_cnt  <= '0;
                  win_timer <= WIN_W'(WINDOW_CYCLES - 1);
                  edge_cnt  <= 16'd0;
               end else begin
                  stab_cnt <= stab_cnt + STAB_W'(1);
               end
            end

            MEASURE, RUN: begin
               // Lock loss wins over everything, including a window end.
               if (!all_locked) begin
                  state        <= WAIT_LOCK;
                  system_reset <= 1'b1;
                  clock_ok     <= 1'b0;
               end else if (win_timer == '0) begin
                  edge_count <= count_next;
                  edge_cnt   <= 16'd0;
                  win_timer  <= WIN_W'(WINDOW_CYCLES - 1);
                  if (in_range) begin
                     state        <= RUN;
                     system_reset <= 1'b0;
                     clock_ok     <= 1'b1;
                     retry_count  <= 4'd0;
                  end else if (retry_count == 4'(MAX_RETRIES)) begin
                     state        <= FAULT;
                     fault        <= 1'b1;
                     system_reset <= 1'b1;
                     clock_ok     <= 1'b0;
                  end else begin
                     state             <= RECOVER;
                     system_reset      <= 1'b1;
                     clock_ok          <= 1'b0;
                     dcm_reset_request <= 1'b1;
                     pulse_timer       <= PULSE_W'(RESET_PULSE_CYCLES - 1);
                     if (retry_count != 4'hF) begin
                        retry_count <= retry_count + 4'd1;
                     end
                  end
               end else begin
                  win_timer <= win_timer - WIN_W'(1);
                  edge_cnt  <= count_next;
               end
            end

            RECOVER: begin
               if (pulse_timer == '0) begin
                  state             <= WAIT_LOCK;
                  dcm_reset_request <= 1'b0;
               end else begin
                  pulse_timer <= pulse_timer - PULSE_W'(1);
               end
            end

            FAULT: begin
               fault             <= 1'b1;
               system_reset      <= 1'b1;
               clock_ok          <= 1'b0;
               dcm_reset_request <= 1'b0;
            end

            default: begin
               state <= WAIT_LOCK;
            end
         endcase
      end
   end

endmodule
